// File: rtl/tcb_full_pkg.sv
// Shared TCB definitions: channel direction, response mode and block configuration.
package tcb_full_pkg;

  // Transfer direction as carried on the half-duplex wen signal.
  typedef enum logic {
    TCB_READ  = 1'b0,
    TCB_WRITE = 1'b1
  } tcb_dir_t;

  // Behaviour of the response outputs between responses.
  typedef enum logic {
    TCB_HOLD  = 1'b0,
    TCB_CLEAR = 1'b1
  } tcb_mode_t;

  // Elaborated configuration of a TCB subordinate.
  typedef struct packed {
    int        adr;
    int        dat;
    int        dep;
    int        dly;
    int        wts;
    tcb_mode_t mode;
  } tcb_cfg_t;

  localparam int TCB_DLY_MAX = 2;
  localparam int TCB_WTS_MAX = 15;

endpackage

// File: rtl/tcb_full_sub_wait.sv
// Wait-state generator: holds off rdy until a request has been pending WTS cycles.
module tcb_full_sub_wait #(
  parameter int WTS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rdy_fb,
  output logic rdy
);

  logic [3:0] cnt;

  // Count stall cycles of a pending request; a transfer or an idle cycle restarts from zero.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (vld && !rdy_fb) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Ready once the wait states have elapsed; forced low while in reset.
  assign rdy = ~rst & (cnt == 4'(WTS));

endmodule

// File: rtl/tcb_full_sub_mem.sv
// TCB memory subordinate: byte-masked writes, delayed read response, range error.
module tcb_full_sub_mem
  import tcb_full_pkg::*;
#(
  parameter int ADR = 32,
  parameter int DAT = 32,
  parameter int DEP = 256,
  parameter int DLY = 1,
  parameter int WTS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  output logic             rdy,
  input  logic             wen,
  input  logic [ADR-1:0]   adr,
  input  logic [DAT/8-1:0] byt,
  input  logic [DAT-1:0]   wdt,
  output logic [DAT-1:0]   rdt,
  output logic             err
);

  localparam tcb_cfg_t CFG = '{adr: ADR, dat: DAT, dep: DEP, dly: DLY, wts: WTS, mode: TCB_HOLD};
  localparam int BEN = DAT / 8;
  localparam int BOF = $clog2(BEN);
  localparam int IW  = ADR - BOF;
  localparam int AW  = (DEP > 1) ? $clog2(DEP) : 1;

  // Configuration legality, rejected at elaboration.
  if (CFG.dly < 1 || CFG.dly > TCB_DLY_MAX) begin : g_bad_dly
    $error("tcb_full_sub_mem: DLY=%0d outside 1..%0d", DLY, TCB_DLY_MAX);
  end
  if (CFG.wts < 0 || CFG.wts > TCB_WTS_MAX) begin : g_bad_wts
    $error("tcb_full_sub_mem: WTS=%0d outside 0..%0d", WTS, TCB_WTS_MAX);
  end
  if (CFG.dat < 8 || (CFG.dat & (CFG.dat - 1)) != 0) begin : g_bad_dat
    $error("tcb_full_sub_mem: DAT=%0d must be a power of 2 >= 8", DAT);
  end
  if (CFG.mode != TCB_HOLD) begin : g_bad_mode
    $error("tcb_full_sub_mem: only hold-mode responses are implemented");
  end

  logic [DAT-1:0] mem [DEP];

  logic           trn;
  tcb_dir_t       dir;
  logic [IW-1:0]  idx;
  logic           oor;
  logic [DAT-1:0] rd_word;
  logic           unused_adr;

  // Response source feeding the output register, DLY-1 stages behind the transfer.
  logic           src_vld;
  tcb_dir_t       src_dir;
  logic           src_err;
  logic [DAT-1:0] src_dat;

  assign trn        = vld & rdy;
  assign dir        = tcb_dir_t'(wen);
  assign idx        = adr[ADR-1:BOF];
  assign oor        = idx >= IW'(DEP);
  assign rd_word    = oor ? '0 : mem[idx[AW-1:0]];
  // Byte-offset bits do not select anything; folded here so they count as consumed.
  assign unused_adr = ^adr;

  tcb_full_sub_wait #(
    .WTS (CFG.wts)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .vld    (vld),
    .rdy_fb (rdy),
    .rdy    (rdy)
  );

  // Byte-masked write at the transfer edge; out-of-range writes are dropped.
  // NOTE: the array deliberately has no reset so it can map onto RAM and keeps contents across rst.
  always_ff @(posedge clk) begin
    if (trn && dir == TCB_WRITE && !oor) begin
      for (int i = 0; i < BEN; i++) begin
        if (byt[i]) begin
          mem[idx[AW-1:0]][8*i +: 8] <= wdt[8*i +: 8];
        end
      end
    end
  end

  if (CFG.dly == 2) begin : g_dly2
    logic           p_vld;
    tcb_dir_t       p_dir;
    logic           p_err;
    logic [DAT-1:0] p_dat;

    // Extra response stage; clearing p_vld discards a response in flight on reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_vld <= 1'b0;
        p_dir <= TCB_READ;
        p_err <= 1'b0;
        p_dat <= '0;
      end else begin
        p_vld <= trn;
        p_dir <= dir;
        p_err <= oor;
        p_dat <= rd_word;
      end
    end

    assign src_vld = p_vld;
    assign src_dir = p_dir;
    assign src_err = p_err;
    assign src_dat = p_dat;
  end else begin : g_dly1
    assign src_vld = trn;
    assign src_dir = dir;
    assign src_err = oor;
    assign src_dat = rd_word;
  end

  // Response register: err follows every response, rdt only read responses; both hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdt <= '0;
      err <= 1'b0;
    end else if (src_vld) begin
      err <= src_err;
      if (src_dir == TCB_READ) begin
        rdt <= src_dat;
      end
    end
  end

endmodule

// File: tb/tb_tcb_full_sub_mem.sv
// Bench for tcb_full_sub_mem: three configurations checked every cycle against a behavioural model.
module tb_tcb_full_sub_mem;

  logic        clk;
  logic        rst;
  logic        vld [3];
  logic        rdy [3];
  logic        wen [3];
  logic [31:0] adr [3];
  logic [3:0]  byt [3];
  logic [31:0] wdt [3];
  logic [31:0] rdt [3];
  logic        err [3];

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: WTS=0 DLY=1, instance 1: WTS=3 DLY=1, instance 2: WTS=0 DLY=2.
  function automatic int wts_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int dly_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  tcb_full_sub_mem #(.ADR(32), .DAT(32), .DEP(256), .DLY(1), .WTS(0)) dut_a (
    .clk(clk), .rst(rst), .vld(vld[0]), .rdy(rdy[0]), .wen(wen[0]), .adr(adr[0]),
    .byt(byt[0]), .wdt(wdt[0]), .rdt(rdt[0]), .err(err[0]));
  tcb_full_sub_mem #(.ADR(32), .DAT(32), .DEP(256), .DLY(1), .WTS(3)) dut_b (
    .clk(clk), .rst(rst), .vld(vld[1]), .rdy(rdy[1]), .wen(wen[1]), .adr(adr[1]),
    .byt(byt[1]), .wdt(wdt[1]), .rdt(rdt[1]), .err(err[1]));
  tcb_full_sub_mem #(.ADR(32), .DAT(32), .DEP(256), .DLY(2), .WTS(0)) dut_c (
    .clk(clk), .rst(rst), .vld(vld[2]), .rdy(rdy[2]), .wen(wen[2]), .adr(adr[2]),
    .byt(byt[2]), .wdt(wdt[2]), .rdt(rdt[2]), .err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic        w;
    logic        e;
    logic [31:0] d;
  } resp_t;

  resp_t       sched [3][4];   // responses keyed by the cycle they become visible
  logic [31:0] mm    [3][256]; // memory image per instance
  int          run   [3];      // consecutive stalled cycles of the pending request
  logic [31:0] e_rdt [3];
  logic        e_err [3];
  int unsigned cyc = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      run[k]   = 0;
      e_rdt[k] = '0;
      e_err[k] = 1'b0;
      for (int s = 0; s < 4; s++) sched[k][s] = '0;
    end
  end

  // Compare every cycle on the falling edge, then advance the model by the cycle's inputs.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic        e_rdy;
      logic        oor;
      int unsigned widx;
      int unsigned slot;
      if (rst) begin
        for (int s = 0; s < 4; s++) sched[k][s] = '0;
        run[k]   = 0;
        e_rdt[k] = '0;
        e_err[k] = 1'b0;
        e_rdy    = 1'b0;
      end else begin
        slot = cyc % 4;
        if (sched[k][slot].v) begin
          e_err[k] = sched[k][slot].e;
          if (!sched[k][slot].w) e_rdt[k] = sched[k][slot].d;
          sched[k][slot] = '0;
        end
        e_rdy = (run[k] == wts_of(k));
      end
      check($sformatf("rdy%0d", k), {31'b0, rdy[k]}, {31'b0, e_rdy});
      check($sformatf("rdt%0d", k), rdt[k], e_rdt[k]);
      check($sformatf("err%0d", k), {31'b0, err[k]}, {31'b0, e_err[k]});
      if (!rst) begin
        if (vld[k] && e_rdy) begin
          widx = adr[k] >> 2;
          oor  = (widx >= 256);
          slot = (cyc + dly_of(k)) % 4;
          sched[k][slot].v = 1'b1;
          sched[k][slot].w = wen[k];
          sched[k][slot].e = oor;
          sched[k][slot].d = oor ? 32'h0 : mm[k][widx[7:0]];
          if (wen[k] && !oor) begin
            for (int b = 0; b < 4; b++)
              if (byt[k][b]) mm[k][widx[7:0]][8*b +: 8] = wdt[k][8*b +: 8];
          end
          run[k] = 0;
        end else if (vld[k]) begin
          run[k] = run[k] + 1;
        end else begin
          run[k] = 0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Issue one request (called #1 after a rising edge); returns after its transfer edge with vld low.
  task automatic req(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    vld[k] = 1'b1; wen[k] = w; adr[k] = a; byt[k] = b; wdt[k] = d;
    while (!done) begin
      @(negedge clk);
      done = rdy[k];
      n++;
      @(posedge clk);
      #1;
      if (!done && n >= 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL req_timeout%0d: no rdy after %0d cycles, required within 40", k, n);
        done = 1'b1;
      end
    end
    vld[k] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] a;
    logic [31:0] vals [4];
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; wen[k] = 1'b0; adr[k] = '0; byt[k] = '0; wdt[k] = '0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(2);
    check("rst_rdy", {31'b0, rdy[0]}, 32'd0);
    check("rst_rdt", rdt[0], 32'd0);
    check("rst_err", {31'b0, err[0]}, 32'd0);
    rst = 1'b0;

    // First transfer on the first edge after release, then read-after-write.
    req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n);
    check("first_xfer_cycles", n, 32'd1);
    req(0, 1'b0, 32'h10, 4'h0, 32'h0, n);
    check("raw_rdt", rdt[0], 32'hDEADBEEF);
    check("raw_err", {31'b0, err[0]}, 32'd0);

    // Partial byte write merge.
    req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, n);
    req(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, n);
    req(0, 1'b0, 32'h20, 4'h0, 32'h0, n);
    check("merge_rdt", rdt[0], 32'h11BB33DD);
    @(negedge clk); #1;
    check("merge_model", e_rdt[0], 32'h11BB33DD);
    tick(1);

    // Out-of-range read and write.
    req(0, 1'b1, 32'h000, 4'hF, 32'h0BADF00D, n);
    req(0, 1'b0, 32'h400, 4'h0, 32'h0, n);
    check("oor_rdt", rdt[0], 32'h0);
    check("oor_err", {31'b0, err[0]}, 32'd1);
    req(0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, n);
    req(0, 1'b0, 32'h000, 4'h0, 32'h0, n);
    check("oor_w0_rdt", rdt[0], 32'h0BADF00D);
    check("oor_w0_err", {31'b0, err[0]}, 32'd0);

    // Wait states: rdy on the 4th cycle of vld, no credit kept across gaps.
    req(1, 1'b1, 32'h8, 4'hF, 32'h5555AAAA, n);
    check("wts_first", n, 32'd4);
    tick(1);
    req(1, 1'b0, 32'h8, 4'h0, 32'h0, n);
    check("wts_second", n, 32'd4);
    vld[1] = 1'b1; wen[1] = 1'b0; adr[1] = 32'h8;
    tick(2);
    vld[1] = 1'b0;
    tick(1);
    req(1, 1'b0, 32'h8, 4'h0, 32'h0, n);
    check("wts_no_credit", n, 32'd4);

    // Reset in the middle of a stall clears the wait count.
    vld[1] = 1'b1; wen[1] = 1'b0; adr[1] = 32'h8;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req(1, 1'b0, 32'h8, 4'h0, 32'h0, n);
    check("wts_after_rst", n, 32'd4);

    // DLY=2: four back-to-back reads answered on four consecutive cycles.
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hA1A1A1A1; vals[2] = 32'hA2A2A2A2; vals[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) req(2, 1'b1, 32'(i * 4), 4'hF, vals[i], n);
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        vld[2] = 1'b1; wen[2] = 1'b0; adr[2] = 32'(j * 4);
      end else begin
        vld[2] = 1'b0;
      end
      if (j >= 2) check($sformatf("dly2_rd%0d", j - 2), rdt[2], vals[j-2]);
      tick(1);
    end

    // Reset one cycle after a read with DLY=2: the response is discarded.
    req(2, 1'b0, 32'h4, 4'h0, 32'h0, n);
    rst = 1'b1;
    #1;
    check("rst_flight_rdt", rdt[2], 32'h0);
    check("rst_flight_err", {31'b0, err[2]}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("rst_late_rdt", rdt[2], 32'h0);
    check("rst_late_err", {31'b0, err[2]}, 32'd0);

    // Preload every word so random reads have known contents.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 256; w++) req(k, 1'b1, 32'(w * 4), 4'hF, $urandom(), n);

    // Random traffic with gaps, abandoned stalls and out-of-range addresses.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 63) * 4);
        else                           a = 32'($urandom_range(0, 255) * 4);
        a[1:0] = 2'($urandom_range(0, 3));
        req(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(), n);
        case ($urandom_range(0, 5))
          0: tick(1);
          1: begin
            vld[k] = 1'b1; wen[k] = 1'b0; adr[k] = 32'($urandom_range(0, 255) * 4);
            tick($urandom_range(1, 2));
            vld[k] = 1'b0;
            tick(1);
          end
          default: ;
        endcase
      end
    end

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
